// File: rtl/rd_ptr_empty.sv
// rtl/rd_ptr_empty.sv - read-domain pointer, empty/level flags and underflow for a dual-clock FIFO
//
// Purpose:
//   Read-side half of an asynchronous FIFO. Brings the write-domain Gray
//   pointer into clk_rd through a two-flop synchroniser, advances the binary
//   read pointer on accepted reads, and derives registered empty,
//   almost-empty, level and underflow indications.
//
// Ports:
//   clk_rd            read-domain clock
//   rst_n             asynchronous active-low reset (synchronised release internally)
//   i_rd_en           read request from the consumer
//   i_wr_gray_ptr     write-domain Gray pointer (PtrWidth+1 bits, asynchronous)
//   o_rd_ptr          RAM read address (PtrWidth bits, registered)
//   o_rd_gray_ptr     registered Gray read pointer for the write-domain synchroniser
//   o_rd_empty        FIFO empty flag, also the RAM empty qualifier
//   o_rd_almost_empty level <= AlmostEmptyThresh
//   o_rd_level        occupancy seen by the read domain, 0..Depth
//   o_rd_underflow    one-cycle pulse for a read attempted while empty

module rd_ptr_empty #(
  parameter int Depth             = 8,
  parameter int PtrWidth          = $clog2(Depth),
  parameter int AlmostEmptyThresh = 1
) (
  input  logic                clk_rd,
  input  logic                rst_n,
  input  logic                i_rd_en,
  input  logic [PtrWidth:0]   i_wr_gray_ptr,
  output logic [PtrWidth-1:0] o_rd_ptr,
  output logic [PtrWidth:0]   o_rd_gray_ptr,
  output logic                o_rd_empty,
  output logic                o_rd_almost_empty,
  output logic [PtrWidth:0]   o_rd_level,
  output logic                o_rd_underflow
);

  localparam logic [PtrWidth:0] AeThresh = (PtrWidth + 1)'(AlmostEmptyThresh);

  // Reset synchroniser: assertion is immediate, release is two clk_rd edges
  // later, which also keeps i_rd_en ignored for those two edges.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  // Write pointer synchroniser; nothing may sit between the two stages.
  logic [PtrWidth:0] wq1_q;
  logic [PtrWidth:0] wq2_q;

  always_ff @(posedge clk_rd or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= i_wr_gray_ptr;
      wq2_q <= wq1_q;
    end
  end

  // Read pointer state and registered flags.
  logic [PtrWidth:0] rd_bin_q,    rd_bin_d;
  logic [PtrWidth:0] rd_gray_q,   rd_gray_d;
  logic [PtrWidth:0] level_q,     level_d;
  logic              empty_q,     empty_d;
  logic              almost_q,    almost_d;
  logic              underflow_q, underflow_d;
  logic              rd_inc;
  logic [PtrWidth:0] wr_bin;

  always_comb begin
    // A read is only accepted against the registered empty flag, so an
    // underflowing request never moves the pointer.
    rd_inc    = i_rd_en & ~empty_q;
    rd_bin_d  = rd_bin_q + {{PtrWidth{1'b0}}, rd_inc};
    rd_gray_d = (rd_bin_d >> 1) ^ rd_bin_d;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    wr_bin = '0;
    for (int i = 0; i <= PtrWidth; i++) begin
      wr_bin[i] = ^(wq2_q >> i);
    end

    // Flags look at the post-read pointer so the read that takes the last
    // entry raises empty on the same edge.
    level_d     = wr_bin - rd_bin_d;
    empty_d     = (rd_gray_d == wq2_q);
    almost_d    = (level_d <= AeThresh);
    underflow_d = i_rd_en & empty_q;
  end

  always_ff @(posedge clk_rd or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      almost_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      almost_q    <= almost_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_rd_ptr          = rd_bin_q[PtrWidth-1:0];
  assign o_rd_gray_ptr     = rd_gray_q;
  assign o_rd_empty        = empty_q;
  assign o_rd_almost_empty = almost_q;
  assign o_rd_level        = level_q;
  assign o_rd_underflow    = underflow_q;

endmodule
